// File: rtl/linked_pipe_demo.sv
// Elastic DEPTH-stage valid/ready register pipeline with occupancy and wrapping transfer count.
// Latency DEPTH edges from accept to output transfer; in_ready is combinational so a full pipe streams when out_ready=1.
module linked_pipe_demo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           xfer_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0]  d_q, d_d;
    logic [DEPTH-1:0]             rdy;
    logic [DEPTH-1:0]             up_v;
    logic [DEPTH-1:0][WIDTH-1:0]  up_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         in_xfer;
    logic                         out_xfer;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_v[k] = in_valid;
            assign up_d[k] = in_data;
        end else begin : g_body
            assign up_v[k] = v_q[k-1];
            assign up_d[k] = d_q[k-1];
        end
    end

    // Unrolled ready chain: a stage can load unless it and every stage after it are full and out_ready is low.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        rdy      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            all_full = all_full & v_q[k];
            rdy[k]   = out_ready | ~all_full;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign in_xfer   = in_valid & rdy[0];
    assign out_xfer  = v_q[DEPTH-1] & out_ready;

    // Data only moves with a valid beat, so an emptied stage keeps its last value.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
                v_d[k] = up_v[k];
                if (up_v[k]) begin
                    d_d[k] = up_d[k];
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        cnt_d = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end

    assign occupancy  = occ_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_linked_pipe_demo.sv
// Directed bench for linked_pipe_demo: vector table for reset/backpressure plus hand-written stream, full-duplex, wrap and reset sequences.
module tb_linked_pipe_demo;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  occupancy;
    logic [15:0] xfer_count;

    logic        w_rst;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [7:0]  w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [7:0]  w_out_data;
    logic [1:0]  w_occupancy;
    logic [3:0]  w_xfer_count;

    int n_chk;
    int n_fail;
    logic [7:0] q[$];

    linked_pipe_demo #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    linked_pipe_demo #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u_wrap (
        .clk        (clk),
        .rst        (w_rst),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .in_data    (w_in_data),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_data   (w_out_data),
        .occupancy  (w_occupancy),
        .xfer_count (w_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  id;
        logic        orr;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [15:0] e_xc;
    } vec_t;

    function automatic vec_t mk(logic r, logic iv, logic [7:0] id, logic orr,
                                logic ov, logic [7:0] od, logic ir, logic [1:0] occ, logic [15:0] xc);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.orr = orr;
        v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_occ = occ; v.e_xc = xc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard step for the main DUT, sampled just before the coming edge.
    task automatic sb_sample();
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("sb_extra_beat", 32'd1, 32'd0);
            else               chk("sb_data", {24'd0, out_data}, {24'd0, q.pop_front()});
        end
        if (in_valid && in_ready) q.push_back(in_data);
    endtask

    vec_t tbl[13];

    initial begin
        int sent, acc0, out0, wsent, wgot;
        logic [15:0] xc0;
        n_chk = 0; n_fail = 0;

        tbl[0]  = mk(0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 0);
        tbl[1]  = mk(0, 1, 8'hA0, 0,  0, 8'h00, 1, 0, 0);
        tbl[2]  = mk(0, 1, 8'hA1, 0,  0, 8'h00, 1, 1, 0);
        tbl[3]  = mk(0, 1, 8'hA2, 0,  0, 8'h00, 1, 2, 0);
        tbl[4]  = mk(0, 1, 8'hA3, 0,  1, 8'hA0, 0, 3, 0);
        tbl[5]  = mk(0, 1, 8'hA3, 0,  1, 8'hA0, 0, 3, 0);
        tbl[6]  = mk(0, 1, 8'hA3, 1,  1, 8'hA0, 1, 3, 0);
        tbl[7]  = mk(0, 1, 8'hA4, 1,  1, 8'hA1, 1, 3, 1);
        tbl[8]  = mk(0, 0, 8'h00, 1,  1, 8'hA2, 1, 3, 2);
        tbl[9]  = mk(0, 0, 8'h00, 1,  1, 8'hA3, 1, 2, 3);
        tbl[10] = mk(0, 0, 8'h00, 1,  1, 8'hA4, 1, 1, 4);
        tbl[11] = mk(0, 0, 8'h00, 1,  0, 8'hA4, 1, 0, 5);
        tbl[12] = mk(0, 0, 8'h00, 0,  0, 8'hA4, 1, 0, 5);

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        w_rst = 1'b1; w_in_valid = 1'b0; w_in_data = 8'h00; w_out_ready = 1'b0;
        tick();
        tick();

        // Reset state and backpressure A0..A4
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].orr;
            #1;
            chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d.out_data", i), {24'd0, out_data}, {24'd0, tbl[i].e_od});
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("vec%0d.occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].e_occ});
            chk($sformatf("vec%0d.xfer_count", i), {16'd0, xfer_count}, {16'd0, tbl[i].e_xc});
            tick();
        end

        // Stream 0x01..0x10 with out_ready=1
        rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
        out_ready = 1'b1; sent = 0; acc0 = -100; out0 = 0;
        for (int c = 0; c < 40 && (sent < 16 || occupancy != 0); c++) begin
            in_valid = (sent < 16);
            in_data  = 8'(sent + 1);
            #1;
            if (in_valid) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (in_valid && in_ready && in_data == 8'h01) acc0 = c;
            if (out_valid && out_ready && out_data == 8'h01) out0 = c;
            if (in_valid && in_ready) sent++;
            sb_sample();
            tick();
        end
        in_valid = 1'b0;
        chk("stream_latency", 32'(out0 - acc0), 32'd3);
        chk("stream_xfer_count", {16'd0, xfer_count}, 32'd16);
        chk("stream_occupancy", {30'd0, occupancy}, 32'd0);
        chk("stream_leftover", 32'(q.size()), 32'd0);

        // Fill, then 4 cycles of simultaneous in/out on a full pipe
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_data = 8'(8'hB0 + j);
            #1; sb_sample(); tick();
        end
        in_valid = 1'b0; #1;
        chk("full_occupancy", {30'd0, occupancy}, 32'd3);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        xc0 = xfer_count;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(8'hB3 + j);
            #1;
            chk("simul_in_ready", {31'd0, in_ready}, 32'd1);
            chk("simul_occupancy", {30'd0, occupancy}, 32'd3);
            sb_sample(); tick();
        end
        in_valid = 1'b0;
        chk("simul_xfer_count", {16'd0, xfer_count}, {16'd0, xc0 + 16'd4});
        chk("simul_occ_after", {30'd0, occupancy}, 32'd3);
        for (int c = 0; c < 8 && occupancy != 0; c++) begin
            #1; sb_sample(); tick();
        end
        chk("simul_drain_occ", {30'd0, occupancy}, 32'd0);
        chk("simul_leftover", 32'(q.size()), 32'd0);

        // Mid-operation reset with occupancy 2 and a beat on offer
        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + j); tick();
        end
        in_valid = 1'b0; #1;
        chk("midrst_pre_occ", {30'd0, occupancy}, 32'd2);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hC2;
        tick();
        rst = 1'b0; in_valid = 1'b0; #1;
        chk("midrst_occ", {30'd0, occupancy}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_xfer_count", {16'd0, xfer_count}, 32'd0);
        chk("midrst_out_data", {24'd0, out_data}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("midrst_no_accept_occ", {30'd0, occupancy}, 32'd0);
        chk("midrst_no_accept_ov", {31'd0, out_valid}, 32'd0);

        // CNT_W=4 wrap after 17 output transfers
        w_rst = 1'b0; w_out_ready = 1'b1; wsent = 0; wgot = 0;
        for (int c = 0; c < 60 && wgot < 17; c++) begin
            w_in_valid = (wsent < 17);
            w_in_data  = 8'(wsent);
            #1;
            if (w_out_valid && w_out_ready) wgot++;
            if (w_in_valid && w_in_ready) wsent++;
            tick();
        end
        w_in_valid = 1'b0;
        chk("wrap_transfers", 32'(wgot), 32'd17);
        chk("wrap_xfer_count", {28'd0, w_xfer_count}, 32'd1);
        chk("wrap_occupancy", {30'd0, w_occupancy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
